// File: rtl/skin_pkg.sv
// Shared constants and helpers for the skin region statistics block.
// Holds coordinate width, mask bytes, default threshold and image size.
package skin_pkg;

    localparam int COORD_W = 16;

    localparam logic [7:0] MASK_ON  = 8'hFF;
    localparam logic [7:0] MASK_OFF = 8'h00;

    localparam logic [7:0] DEF_THRESH     = 8'd128;
    localparam int         DEF_IMG_WIDTH  = 640;
    localparam int         DEF_IMG_HEIGHT = 480;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic coord_t cmin(coord_t a, coord_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic coord_t cmax(coord_t a, coord_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/skin_region_stat_if.sv
// Pixel stream bundle: input (datain_*) and output (dataout_*) handshakes.
// master = stream source/sink side, slave = skin_region_stat.
interface skin_region_stat_if #(
    parameter int DATA_WIDTH = 32
);

    logic                  datain_valid;
    logic                  datain_ready;
    logic                  datain_sof;
    logic [DATA_WIDTH-1:0] datain;

    logic                  dataout_valid;
    logic                  dataout_ready;
    logic [DATA_WIDTH-1:0] dataout;

    modport master (
        output datain_valid, datain, datain_sof,
        input  datain_ready,
        input  dataout_valid, dataout,
        output dataout_ready
    );

    modport slave (
        input  datain_valid, datain, datain_sof,
        output datain_ready,
        output dataout_valid, dataout,
        input  dataout_ready
    );

endinterface

// File: rtl/skid_buffer_2.sv
// Two-entry skid buffer; in_ready is a register so out_ready never
// reaches it combinationally. Ports: in_* push side, out_* pop side.
module skid_buffer_2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       occ;
    logic [1:0]       occ_n;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push = in_valid && ready_q;
    assign pop  = (occ != 2'd0) && out_ready;

    always_comb begin
        occ_n = occ + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            occ     <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ     <= occ_n;
            // ready reflects next-cycle occupancy, so it is exact yet registered
            ready_q <= (occ_n != 2'd2);
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (occ != 2'd0);
    assign out_data  = mem[rd_ptr];

endmodule

// File: rtl/skin_region_stat.sv
// Skin mask + per-frame bounding box / count of skin pixels.
// Ports: clk, rst, stream bus s, bbox_* / skin_count / sync_err results.
module skin_region_stat
    import skin_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int         IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter logic [7:0] THRESH     = DEF_THRESH
) (
    input  logic                clk,
    input  logic                rst,
    skin_region_stat_if.slave   s,
    output logic                bbox_valid,
    output logic                bbox_found,
    output logic [COORD_W-1:0]  bbox_xmin,
    output logic [COORD_W-1:0]  bbox_xmax,
    output logic [COORD_W-1:0]  bbox_ymin,
    output logic [COORD_W-1:0]  bbox_ymax,
    output logic [31:0]         skin_count,
    output logic                sync_err
);

    localparam coord_t X_LAST = coord_t'(IMG_WIDTH - 1);
    localparam coord_t Y_LAST = coord_t'(IMG_HEIGHT - 1);

    logic                  skin;
    logic                  accept;
    logic [DATA_WIDTH-1:0] masked;

    assign skin   = (s.datain[7:0] >= THRESH);
    assign accept = s.datain_valid && s.datain_ready;
    assign masked = {s.datain[DATA_WIDTH-1:8], skin ? MASK_ON : MASK_OFF};

    skid_buffer_2 #(
        .WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s.datain_valid),
        .in_data   (masked),
        .in_ready  (s.datain_ready),
        .out_valid (s.dataout_valid),
        .out_data  (s.dataout),
        .out_ready (s.dataout_ready)
    );

    coord_t      x, y;
    logic        run_found;
    coord_t      run_xmin, run_xmax, run_ymin, run_ymax;
    logic [31:0] run_cnt;

    logic        sof_err;
    coord_t      pos_x, pos_y, nx_x, nx_y;
    logic        base_found, nxt_found, is_last;
    logic [31:0] nxt_cnt;
    coord_t      nxt_xmin, nxt_xmax, nxt_ymin, nxt_ymax;

    always_comb begin
        sof_err    = s.datain_sof && ((x != '0) || (y != '0));
        // a misplaced sof re-anchors this pixel at (0,0) and drops the partial frame
        pos_x      = sof_err ? '0 : x;
        pos_y      = sof_err ? '0 : y;
        base_found = sof_err ? 1'b0 : run_found;
        nxt_cnt    = (sof_err ? 32'd0 : run_cnt) + {31'd0, skin};
        nxt_found  = base_found || skin;
        nxt_xmin   = run_xmin;
        nxt_xmax   = run_xmax;
        nxt_ymin   = run_ymin;
        nxt_ymax   = run_ymax;
        if (skin && !base_found) begin
            nxt_xmin = pos_x;
            nxt_xmax = pos_x;
            nxt_ymin = pos_y;
            nxt_ymax = pos_y;
        end else if (skin) begin
            nxt_xmin = cmin(run_xmin, pos_x);
            nxt_xmax = cmax(run_xmax, pos_x);
            nxt_ymin = cmin(run_ymin, pos_y);
            nxt_ymax = cmax(run_ymax, pos_y);
        end
        is_last = (pos_x == X_LAST) && (pos_y == Y_LAST);
        nx_x    = (pos_x == X_LAST) ? '0 : pos_x + coord_t'(1);
        nx_y    = pos_y;
        if (pos_x == X_LAST) begin
            nx_y = (pos_y == Y_LAST) ? '0 : pos_y + coord_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            run_found  <= 1'b0;
            run_xmin   <= '0;
            run_xmax   <= '0;
            run_ymin   <= '0;
            run_ymax   <= '0;
            run_cnt    <= '0;
            bbox_valid <= 1'b0;
            bbox_found <= 1'b0;
            bbox_xmin  <= '0;
            bbox_xmax  <= '0;
            bbox_ymin  <= '0;
            bbox_ymax  <= '0;
            skin_count <= '0;
            sync_err   <= 1'b0;
        end else begin
            bbox_valid <= 1'b0;
            sync_err   <= 1'b0;
            if (accept) begin
                x        <= nx_x;
                y        <= nx_y;
                sync_err <= sof_err;
                if (is_last) begin
                    // publish now; running stats start empty for the next pixel
                    bbox_valid <= 1'b1;
                    bbox_found <= nxt_found;
                    bbox_xmin  <= nxt_found ? nxt_xmin : '0;
                    bbox_xmax  <= nxt_found ? nxt_xmax : '0;
                    bbox_ymin  <= nxt_found ? nxt_ymin : '0;
                    bbox_ymax  <= nxt_found ? nxt_ymax : '0;
                    skin_count <= nxt_cnt;
                    run_found  <= 1'b0;
                    run_xmin   <= '0;
                    run_xmax   <= '0;
                    run_ymin   <= '0;
                    run_ymax   <= '0;
                    run_cnt    <= '0;
                end else begin
                    run_found <= nxt_found;
                    run_xmin  <= nxt_xmin;
                    run_xmax  <= nxt_xmax;
                    run_ymin  <= nxt_ymin;
                    run_ymax  <= nxt_ymax;
                    run_cnt   <= nxt_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_skin_region_stat.sv
// Scoreboard bench for skin_region_stat on a 4x3 image, threshold 128.
// Stimulus tasks push expectations; a negedge monitor pops and compares.
module tb_skin_region_stat;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    typedef struct {
        logic        found;
        logic [15:0] xmin, xmax, ymin, ymax;
        logic [31:0] cnt;
    } bb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bbox_valid, bbox_found, sync_err;
    logic [15:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
    logic [31:0] skin_count;

    skin_region_stat_if #(.DATA_WIDTH(32)) bus ();

    skin_region_stat #(
        .DATA_WIDTH (32),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .THRESH     (8'd128)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (bus),
        .bbox_valid (bbox_valid),
        .bbox_found (bbox_found),
        .bbox_xmin  (bbox_xmin),
        .bbox_xmax  (bbox_xmax),
        .bbox_ymin  (bbox_ymin),
        .bbox_ymax  (bbox_ymax),
        .skin_count (skin_count),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] exp_pix [$];
    bb_t         exp_bb [$];
    int          bb_times [$];
    int          fx [$];
    int          fy [$];
    bit          fs [$];
    int          m_idx = 0;
    int          exp_sync = 0;
    int          sync_seen = 0;
    int          exp_bb_total = 0;
    int          bb_seen = 0;

    bit          rand_sink = 0;
    bit          stall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (rand_sink) bus.dataout_ready = ($urandom % 4) != 0;
        else           bus.dataout_ready = !stall;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference model: frame as list of (x,y,skin); bbox computed at frame end
    task automatic model_accept(input logic [31:0] d, input logic sof);
        bit  sk;
        bb_t b;
        if (sof && m_idx != 0) begin
            exp_sync++;
            fx.delete(); fy.delete(); fs.delete();
            m_idx = 0;
        end
        sk = d[7:0] >= 8'd128;
        exp_pix.push_back({d[31:8], sk ? 8'hFF : 8'h00});
        fx.push_back(m_idx % W);
        fy.push_back(m_idx / W);
        fs.push_back(sk);
        m_idx++;
        if (m_idx == N) begin
            b = '{1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0};
            b.xmin = 16'hFFFF;
            b.ymin = 16'hFFFF;
            foreach (fs[i]) begin
                if (fs[i]) begin
                    b.found = 1'b1;
                    b.cnt++;
                    if (fx[i] < b.xmin) b.xmin = 16'(fx[i]);
                    if (fx[i] > b.xmax) b.xmax = 16'(fx[i]);
                    if (fy[i] < b.ymin) b.ymin = 16'(fy[i]);
                    if (fy[i] > b.ymax) b.ymax = 16'(fy[i]);
                end
            end
            if (!b.found) begin
                b.xmin = 0;
                b.ymin = 0;
            end
            exp_bb.push_back(b);
            exp_bb_total++;
            fx.delete(); fy.delete(); fs.delete();
            m_idx = 0;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic sof);
        int n;
        bit ok;
        n = 0;
        ok = 0;
        bus.datain_valid = 1'b1;
        bus.datain = d;
        bus.datain_sof = sof;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus.datain_ready && !rst;
            @(posedge clk);
            #1;
            n++;
        end
        if (ok) model_accept(d, sof);
        else chk("accept_timeout", 32'd0, 32'd1);
        bus.datain_valid = 1'b0;
        bus.datain_sof = 1'b0;
    endtask

    task automatic send_score(input logic [7:0] sc, input logic sof);
        logic [31:0] r;
        r = $urandom();
        send({r[31:8], sc}, sof);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_pix.size() != 0 || exp_bb.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, "_datain_ready"}, {31'd0, bus.datain_ready}, 0);
        chk({tag, "_dataout_valid"}, {31'd0, bus.dataout_valid}, 0);
        chk({tag, "_dataout"}, bus.dataout, 0);
        chk({tag, "_bbox_valid"}, {31'd0, bbox_valid}, 0);
        chk({tag, "_bbox_found"}, {31'd0, bbox_found}, 0);
        chk({tag, "_coords"},
            {bbox_xmin | bbox_xmax, bbox_ymin | bbox_ymax}, 0);
        chk({tag, "_skin_count"}, skin_count, 0);
        chk({tag, "_sync_err"}, {31'd0, sync_err}, 0);
    endtask

    logic        prev_hold = 0;
    logic [31:0] prev_data = 0;

    always @(negedge clk) begin
        logic [31:0] e;
        bb_t         b;
        if (!rst) begin
            if (prev_hold) begin
                chk("hold_valid", {31'd0, bus.dataout_valid}, 1);
                chk("hold_data", bus.dataout, prev_data);
            end
            if (bus.dataout_valid && bus.dataout_ready) begin
                if (exp_pix.size() == 0) begin
                    chk("unexpected_pixel", bus.dataout, 32'hDEAD_BEEF);
                end else begin
                    e = exp_pix.pop_front();
                    chk("pixel", bus.dataout, e);
                end
            end
            prev_hold = bus.dataout_valid && !bus.dataout_ready;
            prev_data = bus.dataout;
        end else begin
            prev_hold = 0;
        end
        if (bbox_valid) begin
            bb_seen++;
            bb_times.push_back(cyc);
            if (exp_bb.size() == 0) begin
                chk("unexpected_bbox", 32'd1, 32'd0);
            end else begin
                b = exp_bb.pop_front();
                chk("bb_found", {31'd0, bbox_found}, {31'd0, b.found});
                chk("bb_xmin", {16'd0, bbox_xmin}, {16'd0, b.xmin});
                chk("bb_xmax", {16'd0, bbox_xmax}, {16'd0, b.xmax});
                chk("bb_ymin", {16'd0, bbox_ymin}, {16'd0, b.ymin});
                chk("bb_ymax", {16'd0, bbox_ymax}, {16'd0, b.ymax});
                chk("bb_count", skin_count, b.cnt);
            end
        end
        if (sync_err) sync_seen++;
    end

    initial begin
        int s0;
        logic [7:0] sc;
        bit sof;
        bus.datain_valid = 1'b0;
        bus.datain_sof = 1'b0;
        bus.datain = '0;

        // reset state
        repeat (3) @(posedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", {31'd0, bus.datain_ready}, 1);
        @(posedge clk);
        #1;

        // two skin pixels at (1,0) and (3,2)
        for (int i = 0; i < N; i++) begin
            sc = (i == 1) ? 8'd200 : (i == N - 1) ? 8'd128 : 8'd0;
            send_score(sc, i == 0);
        end
        drain();
        chk("t1_xmin", {16'd0, bbox_xmin}, 1);
        chk("t1_xmax", {16'd0, bbox_xmax}, 3);
        chk("t1_ymin", {16'd0, bbox_ymin}, 0);
        chk("t1_ymax", {16'd0, bbox_ymax}, 2);
        chk("t1_count", skin_count, 2);
        chk("t1_found", {31'd0, bbox_found}, 1);
        chk("t1_pulses", bb_seen, 1);

        // all scores just below threshold
        for (int i = 0; i < N; i++) send_score(8'd127, 1'b0);
        drain();
        chk("t2_found", {31'd0, bbox_found}, 0);
        chk("t2_count", skin_count, 0);
        chk("t2_coords", {bbox_xmin | bbox_xmax, bbox_ymin | bbox_ymax}, 0);

        // output stall mid-frame
        for (int i = 0; i < 4; i++) send_score(8'($urandom_range(0, 255)), i == 0);
        stall = 1;
        fork
            begin
                for (int i = 4; i < N; i++)
                    send_score(8'($urandom_range(0, 255)), 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("stall_ready_low", {31'd0, bus.datain_ready}, 0);
                chk("stall_buffered", exp_pix.size(), 2);
                @(posedge clk);
                #1 stall = 0;
            end
        join
        drain();

        // sof at pixel index 5
        s0 = sync_seen;
        for (int i = 0; i < 5; i++) send_score(8'd250, i == 0);
        for (int i = 0; i < N; i++)
            send_score((i == 6) ? 8'd255 : 8'd10, i == 0);
        drain();
        chk("sof_err_pulse", sync_seen - s0, 1);
        chk("sof_bbox_x", {bbox_xmin, bbox_xmax}, {16'd2, 16'd2});
        chk("sof_bbox_y", {bbox_ymin, bbox_ymax}, {16'd1, 16'd1});

        // back-to-back frames
        for (int i = 0; i < 2 * N; i++)
            send_score(8'($urandom_range(0, 255)), (i % N) == 0);
        drain();
        chk("b2b_spacing", bb_times[$] - bb_times[$-1], N);

        // reset mid-frame after 7 pixels
        for (int i = 0; i < 7; i++) send_score(8'd200, i == 0);
        rst = 1'b1;
        exp_pix.delete();
        fx.delete(); fy.delete(); fs.delete();
        m_idx = 0;
        repeat (2) @(posedge clk);
        chk_reset_vals("midreset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            send_score((i == 4 || i == 7) ? 8'd129 : 8'd3, i == 0);
        drain();
        chk("after_reset_x", {bbox_xmin, bbox_xmax}, {16'd0, 16'd3});
        chk("after_reset_cnt", skin_count, 2);

        // randomized traffic
        rand_sink = 1;
        for (int i = 0; i < 8 * N; i++) begin
            repeat ($urandom % 3) @(posedge clk);
            #1;
            sof = (m_idx == 0) ? 1'($urandom % 2) : (($urandom % 30) == 0);
            send_score(8'($urandom_range(0, 255)), sof);
        end
        for (int i = m_idx; i < N; i++) send_score(8'($urandom_range(0, 255)), 1'b0);
        rand_sink = 0;
        drain();

        chk("bbox_total", bb_seen, exp_bb_total);
        chk("sync_total", sync_seen, exp_sync);
        chk("left_pix", exp_pix.size(), 0);
        chk("left_bb", exp_bb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/skin_region_stat.md
SKIN_REGION_STAT -- requirements
Module: skin_region_stat

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, pixel word width {Y[31:24],Cr[23:16],Cb[15:8],score[7:0]}.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, pixels per line.
REQ-003 SHALL have parameter IMG_HEIGHT, default 480, lines per frame.
REQ-004 SHALL have parameter THRESH, default 8'd128, minimum skin score classed as skin.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have ports datain_valid input 1, datain input DATA_WIDTH, datain_sof input 1 (first pixel of frame), datain_ready output 1.
REQ-008 SHALL have ports dataout_valid output 1, dataout output DATA_WIDTH, dataout_ready input 1.
REQ-009 SHALL have outputs bbox_valid 1, bbox_found 1, bbox_xmin/bbox_xmax/bbox_ymin/bbox_ymax 16 each, skin_count 32, sync_err 1.

Function
REQ-010 Input transfer SHALL occur on cycles with datain_valid && datain_ready; output transfer on dataout_valid && dataout_ready.
REQ-011 Pixel path SHALL be a 2-entry skid buffer; datain_ready = !rst && occupancy < 2, registered, with no combinational path from dataout_ready.
REQ-012 Latency SHALL be 1 cycle from accepted input to dataout_valid when buffer is empty.
REQ-013 dataout SHALL equal {datain[31:8], 8'hFF} if score >= THRESH, else {datain[31:8], 8'h00}; pixel order preserved, no drops or duplicates.
REQ-014 While dataout_valid && !dataout_ready, dataout SHALL hold stable.
REQ-015 Column counter x (0..IMG_WIDTH-1) and row counter y (0..IMG_HEIGHT-1) SHALL advance on each accepted input; x wraps to 0 with y+1; at (IMG_WIDTH-1, IMG_HEIGHT-1) both wrap to 0.
REQ-016 For each accepted skin pixel, running min/max x/y SHALL update and running count SHALL increment; first skin pixel of a frame SHALL load all four extremes.
REQ-017 On accepting the last pixel of a frame, the next cycle SHALL pulse bbox_valid for 1 cycle with results including that last pixel, and clear running stats in that same cycle.
REQ-018 With no skin pixel in the frame: bbox_found=0, coordinates 0, skin_count=0.
REQ-019 Statistic outputs SHALL hold between pulses and SHALL NOT depend on dataout_ready.
REQ-020 datain_sof accepted with (x,y)==(0,0): normal. Accepted with (x,y)!=(0,0): counters restart treating this pixel as (0,0), running stats discarded, no bbox_valid, sync_err pulses 1 cycle.
REQ-021 datain_sof=0 at (0,0) SHALL be accepted without error.
REQ-022 Frame end and new-frame first pixel on consecutive cycles SHALL both be handled with no lost update.

Reset
REQ-023 During rst: datain_ready=0, dataout_valid=0, dataout=0, bbox_valid=0, bbox_found=0, all coordinates 0, skin_count=0, sync_err=0, x=y=0, buffer empty.
REQ-024 datain_ready SHALL rise in the first cycle after rst deasserts.
REQ-025 Reset mid-frame SHALL discard buffered pixels and partial stats with no bbox_valid pulse.

Structure
REQ-026 Shared package skin_pkg SHALL hold COORD_W=16, MASK_ON=8'hFF, MASK_OFF=8'h00, default THRESH and image dimensions.
REQ-027 Skid buffer SHALL be sub-module skid_buffer_2 (parameter WIDTH); counters and stats in top level.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3, THRESH=128)
REQ-028 12 pixels, dataout_ready=1, scores 0 except (1,0)=200 and (3,2)=128 -> masks FF at those two, bbox (1,0)-(3,2), count 2, found 1, one bbox_valid pulse.
REQ-029 Frame of all scores 127 -> all masks 00, bbox_found=0, count 0, coordinates 0.
REQ-030 dataout_ready low for 5 cycles mid-frame -> datain_ready low after 2 buffered pixels, dataout stable, all 12 pixels later delivered in order.
REQ-031 datain_sof at pixel index 5 -> sync_err pulse, no bbox_valid; following 12 pixels produce correct bbox.
REQ-032 Two back-to-back frames, valid continuously high -> two bbox_valid pulses 12 cycles apart, second frame stats independent of first.
REQ-033 rst asserted after pixel 7 -> outputs at reset values, no bbox_valid; next full frame reports correctly.
